// File: rtl/adder_share_arbiter.sv
// Round-robin share of one external WIDTH-bit adder between two requesters.
// One transaction in flight: IDLE accepts, CALC lets the adder settle, RESP holds the result.
module adder_share_arbiter #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic             req1_ready,
  output logic [WIDTH-1:0] add_a,
  output logic [WIDTH-1:0] add_b,
  input  logic [WIDTH-1:0] add_s,
  input  logic             add_cout,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [WIDTH:0]   rsp_sum,
  input  logic             rsp_ready
);

  typedef enum logic [1:0] {IDLE, CALC, RESP} state_t;

  state_t           state_q;
  logic             last_q;
  logic             rsp_valid_q;
  logic             rsp_id_q;
  logic [WIDTH:0]   rsp_sum_q;
  logic [WIDTH-1:0] add_a_q, add_b_q;

  logic             any_valid;
  logic             grant_d;
  logic [WIDTH-1:0] a_d, b_d;

  // On a tie the requester that did not win last time is chosen.
  always_comb begin
    any_valid = req0_valid | req1_valid;
    grant_d   = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    a_d       = grant_d ? req1_a : req0_a;
    b_d       = grant_d ? req1_b : req0_b;
  end

  assign req0_ready = (state_q == IDLE) & any_valid & ~grant_d;
  assign req1_ready = (state_q == IDLE) & any_valid &  grant_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= 1'b0;
      rsp_sum_q   <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_valid) begin
            add_a_q  <= a_d;
            add_b_q  <= b_d;
            rsp_id_q <= grant_d;
            last_q   <= grant_d;
            state_q  <= CALC;
          end
        end
        CALC: begin
          rsp_sum_q   <= {add_cout, add_s};
          rsp_valid_q <= 1'b1;
          state_q     <= RESP;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;

endmodule

// File: tb/tb_adder_share_arbiter.sv
// Directed and randomized checks of adder_share_arbiter with a behavioural adder.
module tb_adder_share_arbiter;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
  logic             req0_ready, req1_ready;
  logic [WIDTH-1:0] add_a, add_b, add_s;
  logic             add_cout;
  logic             rsp_valid, rsp_id, rsp_ready;
  logic [WIDTH:0]   rsp_sum;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  assign {add_cout, add_s} = {1'b0, add_a} + {1'b0, add_b};

  adder_share_arbiter #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
    .add_a(add_a), .add_b(add_b), .add_s(add_s), .add_cout(add_cout),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ready(rsp_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; req0_valid = 0; req1_valid = 0; rsp_ready = 0;
    req0_a = 0; req0_b = 0; req1_a = 0; req1_b = 0;
    step(); step();
    tests++;
    if ({rsp_valid, rsp_id, rsp_sum, add_a, add_b} !== '0) begin
      fails++;
      $display("FAIL reset_outputs: got v=%b id=%b sum=%h a=%h b=%h, want all 0",
               rsp_valid, rsp_id, rsp_sum, add_a, add_b);
    end
    reset = 1'b0;
    req0_valid = 1; req1_valid = 1;
    #1;
    tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      fails++;
      $display("FAIL reset_first_tie: got r0=%b r1=%b, want r0=1 r1=0", req0_ready, req1_ready);
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_single();
    req0_valid = 1; req0_a = 8'h12; req0_b = 8'h34;
    #1;
    tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      fails++;
      $display("FAIL single_ready: got r0=%b r1=%b, want 1 0", req0_ready, req1_ready);
    end
    step();
    req0_valid = 0; req0_a = 8'hAA; req0_b = 8'hBB;
    #1;
    tests++;
    if (req0_ready !== 1'b0 || rsp_valid !== 1'b0 || add_a !== 8'h12 || add_b !== 8'h34) begin
      fails++;
      $display("FAIL single_calc: got r0=%b v=%b a=%h b=%h, want 0 0 12 34",
               req0_ready, rsp_valid, add_a, add_b);
    end
    step();
    tests++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_sum !== 9'h046) begin
      fails++;
      $display("FAIL single_rsp: got v=%b id=%b sum=%h, want 1 0 046", rsp_valid, rsp_id, rsp_sum);
    end
    rsp_ready = 1;
    step();
    tests++;
    if (rsp_valid !== 1'b0) begin
      fails++;
      $display("FAIL single_done: got v=%b, want 0", rsp_valid);
    end
    rsp_ready = 0;
  endtask

  task automatic test_overflow();
    logic [7:0] ta [2];
    logic [8:0] te [2];
    ta[0] = 8'hFF; te[0] = 9'h1FE;
    ta[1] = 8'h80; te[1] = 9'h100;
    for (int k = 0; k < 2; k++) begin
      req1_valid = 1; req1_a = ta[k]; req1_b = ta[k];
      #1;
      tests++;
      if ({req0_ready, req1_ready} !== 2'b01) begin
        fails++;
        $display("FAIL overflow_ready%0d: got r0=%b r1=%b, want 0 1", k, req0_ready, req1_ready);
      end
      step();
      req1_valid = 0;
      step();
      tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_sum !== te[k]) begin
        fails++;
        $display("FAIL overflow_rsp%0d: got v=%b id=%b sum=%h, want 1 1 %h",
                 k, rsp_valid, rsp_id, rsp_sum, te[k]);
      end
      rsp_ready = 1;
      step();
      rsp_ready = 0;
    end
  endtask

  task automatic test_alternate();
    logic       exp_id;
    logic [8:0] exp_sum;
    req0_valid = 1; req0_a = 8'h01; req0_b = 8'h02;
    req1_valid = 1; req1_a = 8'h40; req1_b = 8'hC0;
    rsp_ready  = 1;
    for (int k = 0; k < 4; k++) begin
      exp_id  = k[0];
      exp_sum = exp_id ? 9'h100 : 9'h003;
      #1;
      tests++;
      if (req0_ready !== ~exp_id || req1_ready !== exp_id) begin
        fails++;
        $display("FAIL alt_grant%0d: got r0=%b r1=%b, want grant %0d", k, req0_ready, req1_ready, exp_id);
      end
      step();
      tests++;
      if ({req0_ready, req1_ready, rsp_valid} !== 3'b000) begin
        fails++;
        $display("FAIL alt_calc%0d: got r0=%b r1=%b v=%b, want 0 0 0", k, req0_ready, req1_ready, rsp_valid);
      end
      step();
      tests++;
      if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_sum !== exp_sum) begin
        fails++;
        $display("FAIL alt_rsp%0d: got v=%b id=%b sum=%h, want 1 %0d %h",
                 k, rsp_valid, rsp_id, rsp_sum, exp_id, exp_sum);
      end
      step();
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
  endtask

  task automatic test_backpressure();
    req0_valid = 1; req0_a = 8'h55; req0_b = 8'h0A;
    step();
    req0_valid = 0;
    step();
    req1_valid = 1; req1_a = 8'h03; req1_b = 8'h04;
    for (int k = 0; k < 10; k++) begin
      #1;
      tests++;
      if (rsp_valid !== 1'b1 || rsp_sum !== 9'h05F || rsp_id !== 1'b0 ||
          req0_ready !== 1'b0 || req1_ready !== 1'b0) begin
        fails++;
        $display("FAIL bp_hold%0d: got v=%b id=%b sum=%h r0=%b r1=%b, want 1 0 05F 0 0",
                 k, rsp_valid, rsp_id, rsp_sum, req0_ready, req1_ready);
      end
      step();
    end
    rsp_ready = 1;
    step();
    tests++;
    if (rsp_valid !== 1'b0 || req1_ready !== 1'b1) begin
      fails++;
      $display("FAIL bp_release: got v=%b r1=%b, want 0 1", rsp_valid, req1_ready);
    end
    req1_valid = 0; rsp_ready = 0;
  endtask

  task automatic test_reset_mid();
    req0_valid = 1; req0_a = 8'h01; req0_b = 8'h01;
    step();
    req0_valid = 0;
    reset = 1;
    step();
    reset = 0;
    tests++;
    if ({rsp_valid, rsp_id, rsp_sum, add_a, add_b} !== '0) begin
      fails++;
      $display("FAIL midreset_outputs: got v=%b id=%b sum=%h a=%h b=%h, want all 0",
               rsp_valid, rsp_id, rsp_sum, add_a, add_b);
    end
    for (int k = 0; k < 4; k++) begin
      step();
      tests++;
      if (rsp_valid !== 1'b0) begin
        fails++;
        $display("FAIL midreset_norsp%0d: got v=%b, want 0", k, rsp_valid);
      end
    end
    req0_valid = 1; req1_valid = 1;
    #1;
    tests++;
    if ({req0_ready, req1_ready} !== 2'b10) begin
      fails++;
      $display("FAIL midreset_tie: got r0=%b r1=%b, want 1 0", req0_ready, req1_ready);
    end
    req0_valid = 0; req1_valid = 0;
  endtask

  task automatic test_random();
    logic [9:0] q[$];
    logic [9:0] exp;
    logic       acc0, acc1;
    int         accepts, cyc;
    acc0 = 0; acc1 = 0; accepts = 0; cyc = 0;
    while ((accepts < 1000 || q.size() > 0) && cyc < 20000) begin
      step();
      cyc++;
      if (!req0_valid || acc0) begin
        req0_valid = (accepts < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
        req0_a = 8'($urandom); req0_b = 8'($urandom);
      end
      if (!req1_valid || acc1) begin
        req1_valid = (accepts < 1000) ? 1'($urandom_range(0, 1)) : 1'b0;
        req1_a = 8'($urandom); req1_b = 8'($urandom);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      #1;
      acc0 = req0_ready;
      acc1 = req1_ready;
      if (acc0) begin q.push_back({1'b0, {1'b0, req0_a} + {1'b0, req0_b}}); accepts++; end
      if (acc1) begin q.push_back({1'b1, {1'b0, req1_a} + {1'b0, req1_b}}); accepts++; end
      if (rsp_valid && rsp_ready) begin
        tests++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL rand_extra_rsp: got id=%b sum=%h, want no response", rsp_id, rsp_sum);
        end else begin
          exp = q.pop_front();
          if ({rsp_id, rsp_sum} !== exp) begin
            fails++;
            $display("FAIL rand_rsp: got id=%b sum=%h, want id=%b sum=%h",
                     rsp_id, rsp_sum, exp[9], exp[8:0]);
          end
        end
      end
    end
    tests++;
    if (accepts < 1000 || q.size() != 0) begin
      fails++;
      $display("FAIL rand_complete: got %0d accepts, %0d pending, want 1000 and 0", accepts, q.size());
    end
    req0_valid = 0; req1_valid = 0; rsp_ready = 0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_overflow();
    test_alternate();
    test_backpressure();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
